// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: Moore main FSM, NZCV flag register, latched condition result.
// Optional `MEM_READY_EN adds a MemReady input that stalls FETCH/MEMREAD/MEMWRITE.
//
// state    | meaning
// FETCH    | read instruction at PC into IR, PC <= PC+4
// DECODE   | read registers, form PC+8, latch condition result
// MEMADR   | base +/- immediate offset for LDR/STR
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded data to Rd (or PC)
// MEMWRITE | write RD2 to data memory at ALUOut
// EXECR    | data-processing with register operand
// EXECI    | data-processing with immediate operand
// ALUWB    | write ALU result to Rd (or PC)
// BRANCH   | PC <= PC+8+offset when condition holds
module multicycle_controller #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
`ifdef MEM_READY_EN
    input  logic        MemReady,
`endif
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  ALUControl,
    output logic [3:0]  State
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_e;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_ORR  = 4'b0011;
    localparam logic [3:0] ALU_PASS = 4'b0100;

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex_q, cond_ex_d;
    logic       mem_rdy;

`ifdef MEM_READY_EN
    assign mem_rdy = MemReady;
`else
    assign mem_rdy = 1'b1;
`endif

    // Instr holds instruction bits [31:12], so field offsets are shifted down by 12.
    logic [3:0] cond, cmd, rd;
    logic [1:0] op;
    logic       i_bit, u_bit, s_bit, unused_rn;
    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign i_bit     = Instr[13];
    assign cmd       = Instr[12:9];
    assign u_bit     = Instr[11];
    assign s_bit     = Instr[8];
    assign unused_rn = ^Instr[7:4];
    assign rd        = Instr[3:0];

    logic [3:0] dp_alu;
    logic       dp_wr, dp_flag, dp_cv, is_cmp;

    always_comb begin
        dp_alu  = ALU_PASS;
        dp_wr   = 1'b0;
        dp_flag = 1'b0;
        dp_cv   = 1'b0;
        is_cmp  = 1'b0;
        case (cmd)
            4'b0100: begin dp_alu = ALU_ADD;  dp_wr = 1'b1; dp_flag = 1'b1; dp_cv = 1'b1; end
            4'b0010: begin dp_alu = ALU_SUB;  dp_wr = 1'b1; dp_flag = 1'b1; dp_cv = 1'b1; end
            4'b0000: begin dp_alu = ALU_AND;  dp_wr = 1'b1; dp_flag = 1'b1; end
            4'b1100: begin dp_alu = ALU_ORR;  dp_wr = 1'b1; dp_flag = 1'b1; end
            4'b1010: begin dp_alu = ALU_SUB;  dp_flag = 1'b1; dp_cv = 1'b1; is_cmp = 1'b1; end
            4'b1101: begin dp_alu = ALU_PASS; dp_wr = 1'b1; dp_flag = 1'b1; end
            default: ;
        endcase
    end

    logic f_n, f_z, f_c, f_v, cond_pass;
    assign {f_n, f_z, f_c, f_v} = flags_q;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = f_z;
            4'b0001: cond_pass = !f_z;
            4'b0010: cond_pass = f_c;
            4'b0011: cond_pass = !f_c;
            4'b0100: cond_pass = f_n;
            4'b0101: cond_pass = !f_n;
            4'b0110: cond_pass = f_v;
            4'b0111: cond_pass = !f_v;
            4'b1000: cond_pass = f_c && !f_z;
            4'b1001: cond_pass = !f_c || f_z;
            4'b1010: cond_pass = (f_n == f_v);
            4'b1011: cond_pass = (f_n != f_v);
            4'b1100: cond_pass = !f_z && (f_n == f_v);
            4'b1101: cond_pass = f_z || (f_n != f_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = FETCH;
        cond_ex_d  = cond_ex_q;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = op;
        RegSrc     = {(op == 2'b01) && !s_bit, op == 2'b10};
        case (state_q)
            FETCH: begin
                IRWrite   = mem_rdy;
                PCWrite   = mem_rdy;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = mem_rdy ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                cond_ex_d = cond_pass;
                case (op)
                    2'b00:   state_d = i_bit ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = u_bit ? ALU_ADD : ALU_SUB;
                state_d    = s_bit ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = mem_rdy ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                PCWrite   = cond_ex_q && (rd == 4'hF);
                RegWrite  = cond_ex_q && (rd != 4'hF);
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex_q;
                state_d  = mem_rdy ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUControl = dp_alu;
                state_d    = ALUWB;
            end
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dp_alu;
                state_d    = ALUWB;
            end
            ALUWB: begin
                PCWrite  = dp_wr && cond_ex_q && (rd == 4'hF);
                RegWrite = dp_wr && cond_ex_q && (rd != 4'hF);
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex_q;
            end
            default: state_d = FETCH;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            IRWrite  = 1'b0;
        end
    end

    // CV only come from the adder; logical ops and MOV leave them alone.
    always_comb begin
        flags_d = flags_q;
        if ((state_q == EXECR || state_q == EXECI) && cond_ex_q && dp_flag && (s_bit || is_cmp)) begin
            flags_d[3:2] = ALUFlags[3:2];
            if (dp_cv) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            flags_q   <= FLAGS_RST;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    assign State = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed ARM sequences then random instructions vs an instruction-level model.
module tb_multicycle_controller;
    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [3:0]  ALUControl, State;
`ifdef MEM_READY_EN
    logic        mem_ready = 1'b1;
`endif

    int checks   = 0;
    int failures = 0;
    logic [3:0] flags_m = 4'b0000;
    logic [3:0] cmds [6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1101};

    multicycle_controller dut (
        .clk       (clk),
        .reset     (reset),
        .Instr     (Instr),
        .ALUFlags  (ALUFlags),
`ifdef MEM_READY_EN
        .MemReady  (mem_ready),
`endif
        .PCWrite   (PCWrite),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .ALUControl(ALUControl),
        .State     (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Base test on cond[3:1], bit 0 inverts it; 1111 falls out as "never".
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf & !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic dp_info(input logic [3:0] cmd, output logic [3:0] alu,
                           output logic wr, output logic flg, output logic cv);
        alu = 4'b0100; wr = 1'b0; flg = 1'b0; cv = 1'b0;
        if (cmd == 4'b0100) begin alu = 4'b0000; wr = 1; flg = 1; cv = 1; end
        if (cmd == 4'b0010) begin alu = 4'b0001; wr = 1; flg = 1; cv = 1; end
        if (cmd == 4'b0000) begin alu = 4'b0010; wr = 1; flg = 1; end
        if (cmd == 4'b1100) begin alu = 4'b0011; wr = 1; flg = 1; end
        if (cmd == 4'b1010) begin alu = 4'b0001; flg = 1; cv = 1; end
        if (cmd == 4'b1101) begin alu = 4'b0100; wr = 1; flg = 1; end
    endtask

    // {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl} expected in each state
    function automatic logic [9:0] exp_sel(input int s, input logic u, input logic [3:0] dp_alu);
        case (s)
            0:       return {1'b0, 1'b1, 2'b10, 2'b10, 4'b0000};
            1:       return {1'b0, 1'b1, 2'b10, 2'b00, 4'b0000};
            2:       return {1'b0, 1'b0, 2'b01, 2'b00, u ? 4'b0000 : 4'b0001};
            3, 5:    return {1'b1, 1'b0, 2'b00, 2'b00, 4'b0000};
            4:       return {1'b0, 1'b0, 2'b00, 2'b01, 4'b0000};
            6:       return {1'b0, 1'b0, 2'b00, 2'b00, dp_alu};
            7:       return {1'b0, 1'b0, 2'b01, 2'b00, dp_alu};
            9:       return {1'b0, 1'b0, 2'b01, 2'b10, 4'b0000};
            default: return 10'd0;
        endcase
    endfunction

    // Entered at a negedge in FETCH; returns at the negedge of the next FETCH.
    task automatic run_instr(input logic [19:0] ins, input logic [3:0] af);
        int         trace[$];
        int         s;
        logic       pass, wr, flg, cv, wb, rd15;
        logic [3:0] alu;
        Instr    = ins;
        ALUFlags = af;
        pass = cond_holds(ins[19:16], flags_m);
        dp_info(ins[12:9], alu, wr, flg, cv);
        rd15 = (ins[3:0] == 4'hF);
        trace.push_back(0);
        trace.push_back(1);
        if (ins[15:14] == 2'b00) begin
            trace.push_back(ins[13] ? 7 : 6);
            trace.push_back(8);
        end else if (ins[15:14] == 2'b01) begin
            trace.push_back(2);
            if (ins[8]) begin
                trace.push_back(3);
                trace.push_back(4);
            end else begin
                trace.push_back(5);
            end
        end else if (ins[15:14] == 2'b10) begin
            trace.push_back(9);
        end
        foreach (trace[k]) begin
            s = trace[k];
            #1;
            wb = (s == 4) || (s == 8 && wr);
            check("state", 16'(State), 16'(s));
            check("pcwrite", 16'(PCWrite), 16'((s == 0) || (s == 9 && pass) || (wb && rd15 && pass)));
            check("regwrite", 16'(RegWrite), 16'(wb && !rd15 && pass));
            check("memwrite", 16'(MemWrite), 16'(s == 5 && pass));
            check("irwrite", 16'(IRWrite), 16'(s == 0));
            check("selects", 16'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}),
                  16'(exp_sel(s, ins[11], alu)));
            check("imm_regsrc", 16'({ImmSrc, RegSrc}),
                  16'({ins[15:14], (ins[15:14] == 2'b01) && !ins[8], ins[15:14] == 2'b10}));
            @(negedge clk);
        end
        if (ins[15:14] == 2'b00 && pass && flg && (ins[8] || ins[12:9] == 4'b1010)) begin
            flags_m[3:2] = af[3:2];
            if (cv) flags_m[1:0] = af[1:0];
        end
    endtask

    initial begin
        logic [19:0] ins;
        reset    = 1'b1;
        Instr    = 20'hE0821;
        ALUFlags = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            check("rst_state", 16'(State), 16'd0);
            check("rst_wen", 16'({PCWrite, MemWrite, RegWrite, IRWrite}), 16'd0);
        end
        reset = 1'b0;
        run_instr(20'hE0821, 4'b1111);     // ADD R1,R2,R3 (no S): flags stay 0000
        run_instr(20'h0A000, 4'b0000);     // BEQ with Z=0
`ifdef MEM_READY_EN
        mem_ready = 1'b0;
        repeat (3) begin
            #1;
            check("stall_state", 16'(State), 16'd0);
            check("stall_wen", 16'({IRWrite, PCWrite}), 16'd0);
            @(negedge clk);
        end
        mem_ready = 1'b1;
`endif
        run_instr(20'hE0921, 4'b0100);     // ADDS R1,R2,R3 -> Z=1
        run_instr(20'h0A000, 4'b0000);     // BEQ taken
        run_instr(20'hE5910, 4'b0000);     // LDR R0,[R1,#4]
        run_instr(20'hE1510, 4'b0000);     // CMP -> Z=0
        run_instr(20'h05810, 4'b0000);     // STREQ not taken
        run_instr(20'hE1510, 4'b0100);     // CMP -> Z=1
        run_instr(20'h0A000, 4'b0000);     // BEQ taken
        run_instr(20'h1A000, 4'b0000);     // BNE not taken
        run_instr(20'hE1A0F, 4'b1010);     // MOV PC,R2
        run_instr(20'hEC000, 4'b0000);     // op=11 NOP
        run_instr(20'hE1510, 4'b1111);     // CMP -> NZCV=1111

        // ADDS abandoned in ALUWB: writeback suppressed and flags return to reset value
        Instr    = 20'hE0921;
        ALUFlags = 4'b0100;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abandon_state", 16'(State), 16'd8);
        check("abandon_wen", 16'({PCWrite, MemWrite, RegWrite, IRWrite}), 16'd0);
        @(negedge clk);
        reset   = 1'b0;
        flags_m = 4'b0000;
        run_instr(20'h0A000, 4'b0000);     // BEQ must not be taken after flag reset

        for (int n = 0; n < 300; n++) begin
            ins = 20'($urandom);
            if ($urandom_range(0, 1) == 1) ins[19:16] = 4'hE;
            if ($urandom_range(0, 4) != 0) ins[12:9] = cmds[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) ins[3:0] = 4'hF;
            run_instr(ins, 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
